// File: rtl/dmem_responder.sv
// Data-memory responder: latches a strobe request, inserts WAIT_CYC wait states, then does a byte-merged
// array access and returns a one-cycle RDY pulse. Define DMEM_ALIGN_CHK_EN to enable the alignment check.
module dmem_responder #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              D_MEM_CSN,
  input  logic              D_MEM_WEN,
  input  logic [3:0]        D_MEM_BE,
  input  logic [ADDR_W-1:0] D_MEM_ADDR,
  input  logic [31:0]       D_MEM_DI,
  output logic [31:0]       D_MEM_DOUT,
  output logic              D_MEM_RDY,
  output logic              D_MEM_ERR
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_LD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       di_q, di_d;
  logic [31:0]       rd_word_q, rd_word_d;
  logic [31:0]       dout_q, dout_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [0:DEPTH-1];

  logic [ADDR_W-3:0] widx_s;
  logic [31:0]       cur_word_s;
  logic [31:0]       wr_word_s;
  logic [31:0]       rd_mask_s;
  logic              mem_we_s;
  logic              mis_s;

`ifdef DMEM_ALIGN_CHK_EN
  function automatic logic misaligned(input logic [3:0] be, input logic [1:0] lo);
    case (be)
      4'b1111:          return (lo != 2'b00);
      4'b0011, 4'b1100: return lo[0];
      default:          return 1'b0;
    endcase
  endfunction

  assign mis_s = misaligned(be_q, addr_q[1:0]);
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_q[1:0];
  assign mis_s = 1'b0;
`endif

  assign widx_s     = addr_q[ADDR_W-1:2];
  assign cur_word_s = mem_q[widx_s];

  // Lane merge for writes and lane zeroing for reads.
  always_comb begin
    wr_word_s = cur_word_s;
    rd_mask_s = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) begin
        wr_word_s[8*i +: 8] = di_q[8*i +: 8];
        rd_mask_s[8*i +: 8] = cur_word_s[8*i +: 8];
      end else begin
        wr_word_s[8*i +: 8] = cur_word_s[8*i +: 8];
        rd_mask_s[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wen_d     = wen_q;
    be_d      = be_q;
    addr_d    = addr_q;
    di_d      = di_q;
    rd_word_d = rd_word_q;
    dout_d    = dout_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    mem_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!D_MEM_CSN) begin
          wen_d  = D_MEM_WEN;
          be_d   = D_MEM_BE;
          addr_d = D_MEM_ADDR;
          di_d   = D_MEM_DI;
          if (WAIT_CYC == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        rd_word_d = rd_mask_s;
        mem_we_s  = !wen_q && !mis_s;
        state_d   = S_RESP;
      end
      S_RESP: begin
        // Outputs are registered here, so RDY rises on the edge that leaves RESP.
        rdy_d = 1'b1;
        err_d = mis_s;
        if (mis_s) begin
          dout_d = 32'h0000_0000;
        end else if (wen_q) begin
          dout_d = rd_word_q;
        end else begin
          dout_d = dout_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wen_q     <= 1'b1;
      be_q      <= 4'b0000;
      addr_q    <= '0;
      di_q      <= 32'h0000_0000;
      rd_word_q <= 32'h0000_0000;
      dout_q    <= 32'h0000_0000;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wen_q     <= wen_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      rd_word_q <= rd_word_d;
      dout_q    <= dout_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  // The array keeps its contents through reset; only the write itself is blocked.
  always_ff @(posedge CLK) begin
    if (RSTn && mem_we_s) begin
      mem_q[widx_s] <= wr_word_s;
    end
  end

  assign D_MEM_DOUT = dout_q;
  assign D_MEM_RDY  = rdy_q;
  assign D_MEM_ERR  = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multi-cycle core: the target end of the data-memory strobe interface driven by the core controller. It samples the chip-select/write-enable/byte-enable request and holds it for a programmable number of wait states. It then performs the word-array access with per-byte merge and returns a one-cycle ready pulse carrying read data. It replaces the ideal zero-latency data memory so the controller's memory states can be exercised against realistic latency.

## Interface
- ADDR_W, 12: byte-address width; array depth = 2**(ADDR_W-2) 32-bit words.
- WAIT_CYC, 1: wait states inserted before the array access; legal range 0..15.
- CLK  input  1  clock; all state changes on rising edge.
- RSTn  input  1  reset, synchronous, active-low.
- D_MEM_CSN  input  1  chip select, active-low; a request is presented while low.
- D_MEM_WEN  input  1  write enable, active-low (0 = write, 1 = read).
- D_MEM_BE  input  4  byte-lane enables; bit i selects bits [8i+7:8i].
- D_MEM_ADDR  input  ADDR_W  byte address.
- D_MEM_DI  input  32  write data, lane-aligned.
- D_MEM_DOUT  output  32  read data; valid while D_MEM_RDY=1, held afterwards.
- D_MEM_RDY  output  1  one-cycle response pulse, for both reads and writes.
- D_MEM_ERR  output  1  alignment error, valid with D_MEM_RDY.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: if D_MEM_CSN=0 at an edge, latch WEN, BE, ADDR, DI. Go to WAIT and load counter=WAIT_CYC-1, or go directly to ACCESS when WAIT_CYC=0.
- WAIT: decrement the counter each cycle; go to ACCESS on the cycle the counter reads 0.
- ACCESS: word index = latched ADDR[ADDR_W-1:2].
  - Write: update only the bytes whose latched BE bit is 1.
  - Read: capture the word, then zero every lane whose BE bit is 0.
  - Next state is always RESP.
- RESP: D_MEM_RDY=1 and D_MEM_ERR set per the alignment check. Next state is IDLE.
- Request inputs are ignored outside IDLE. A held CSN=0 starts a new request on the first IDLE edge, so back-to-back accesses are spaced WAIT_CYC+3 cycles apart.
- BE=4'b0000: no array change; a read returns DOUT=0; RDY is still pulsed.
- Reads never modify the array. D_MEM_DOUT holds the last read value across write responses.
- Address wrap: bits above ADDR_W do not exist. The top word is 2**(ADDR_W-2)-1 and there is no wrap logic.

## Timing
- Request sampled at edge k. ACCESS occupies cycle k+1+WAIT_CYC. RDY is high for exactly one cycle, starting at edge k+2+WAIT_CYC.
- Read latency = WAIT_CYC+2 cycles. A write is visible to a read whose ACCESS follows it.
- Reset values (RSTn=0 at any edge): state=IDLE, counter=0, D_MEM_RDY=0, D_MEM_ERR=0, D_MEM_DOUT=0.
- The array is not cleared by reset.
- Reset mid-operation: a pending request is discarded, including a write not yet in ACCESS, and no RDY is issued.
- RSTn=0 together with CSN=0 at an edge: the request is not accepted. Reset wins.

## Configuration
- DMEM_ALIGN_CHK_EN defined: a request is misaligned in either case below.
  - BE=4'b1111 and ADDR[1:0]!=0.
  - BE is 4'b0011 or 4'b1100 and ADDR[0]!=0.
  - For a misaligned request, ACCESS suppresses the array write, DOUT is forced to 0, and ERR=1 together with RDY.
- Not defined: ADDR[1:0] is ignored and D_MEM_ERR is tied 0. All requests proceed normally.

## Test plan
- WAIT_CYC=1: write 0xDEADBEEF, BE=1111, ADDR=0x010 at edge 5 -> RDY high in cycle 8, ERR=0. A read of 0x010 then returns 0xDEADBEEF with RDY exactly 3 cycles after its sample edge.
- Byte merge: word 0x010=0xDEADBEEF, write DI=0x00AA0000, BE=0100 -> a BE=1111 read returns 0xDEAABEEF. A BE=0011 read returns 0x0000BEEF.
- WAIT_CYC=0 and WAIT_CYC=15: a read of the same word returns RDY after 2 and 17 cycles respectively. CSN held low gives RDY every 3 and 18 cycles.
- RSTn low during WAIT of a write to 0x020 (old value 0x11111111) -> no RDY, outputs 0. A later read of 0x020 returns 0x11111111.
- BE=0000 write to 0x030 -> RDY pulses and the word is unchanged. A BE=0000 read -> DOUT=0.
- With DMEM_ALIGN_CHK_EN: write BE=1111 to ADDR=0x012 -> RDY=1, ERR=1, word 0x010 unchanged. Without the macro, the same write updates word 0x010 and ERR=0.
